// File: rtl/dso_chan_seq.sv
// Channel sequencer for the 1-bit 2:1 acquisition mux: drives the select, deserialises the mux stream
// into channel-tagged words and offers them on a valid/ready port. Optional word_first: DSO_CHSEQ_FIRST_EN.
module dso_chan_seq #(
   parameter int WORD_W     = 16,
   parameter int DWELL_W    = 16,
   parameter int SETTLE_CYC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [DWELL_W-1:0] dwell,
   output logic               sel_s,
   input  logic               mux_y,
   output logic [WORD_W-1:0]  word_data,
   output logic               word_chan,
   output logic               word_valid,
   input  logic               word_ready,
   output logic               overflow,
   output logic               busy
`ifdef DSO_CHSEQ_FIRST_EN
   ,
   output logic               word_first
`endif
);

   localparam int BIT_CW = $clog2(WORD_W);
   localparam int SET_CW = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SHIFT} state_t;

   state_t              state, state_n;
   logic [SET_CW-1:0]   settle_cnt;
   logic [BIT_CW-1:0]   bit_cnt;
   logic [DWELL_W-1:0]  word_cnt;
   logic [DWELL_W-1:0]  dwell_q;
   logic [DWELL_W-1:0]  dwell_last;
   logic                alt_q;
   logic                en_q;
   logic [WORD_W-2:0]   shift_p0;
   logic [WORD_W-1:0]   shift_n;
   logic                start, word_done, sw;
`ifdef DSO_CHSEQ_FIRST_EN
   logic                first_pend;
`endif

   assign shift_n    = {shift_p0, mux_y};
   assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      start     = 1'b0;
      word_done = 1'b0;
      sw        = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               start   = 1'b1;
               state_n = SETTLE;
            end
         end
         SETTLE: begin
            if (!en)                                     state_n = IDLE;
            else if (settle_cnt == SET_CW'(SETTLE_CYC - 1)) state_n = SHIFT;
         end
         SHIFT: begin
            if (!en) begin
               state_n = IDLE;
            end else if (bit_cnt == BIT_CW'(WORD_W - 1)) begin
               word_done = 1'b1;
               if (alt_q && (word_cnt == dwell_last)) begin
                  sw      = 1'b1;
                  state_n = SETTLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // shift stage: no reset, only meaningful while in SHIFT
   always_ff @(posedge clk) begin
      if (state == SHIFT) shift_p0 <= shift_n[WORD_W-2:0];
   end

   // control, counters and single-entry output register
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_s      <= 1'b1;
         alt_q      <= 1'b0;
         dwell_q    <= '0;
         settle_cnt <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         en_q       <= 1'b0;
         word_data  <= '0;
         word_chan  <= 1'b1;
         word_valid <= 1'b0;
         overflow   <= 1'b0;
`ifdef DSO_CHSEQ_FIRST_EN
         first_pend <= 1'b0;
         word_first <= 1'b0;
`endif
      end else begin
         en_q       <= en;
         settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;

         if (state == SHIFT && en && !word_done) bit_cnt <= bit_cnt + 1'b1;
         else                                    bit_cnt <= '0;

         if (start || sw) begin
            alt_q    <= mode[1];
            dwell_q  <= dwell;
            word_cnt <= '0;
         end else if (word_done && alt_q) begin
            word_cnt <= word_cnt + 1'b1;
         end

         // a mode written during a run only takes hold at the switch
         if (start)   sel_s <= (mode != 2'b01);
         else if (sw) sel_s <= (mode == 2'b00) ? 1'b1 :
                               (mode == 2'b01) ? 1'b0 : ~sel_s;

         if (word_done && (!word_valid || word_ready)) begin
            word_data  <= shift_n;
            word_chan  <= sel_s;
            word_valid <= 1'b1;
`ifdef DSO_CHSEQ_FIRST_EN
            word_first <= first_pend;
`endif
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end

         if (en && !en_q)                               overflow <= 1'b0;
         else if (word_done && word_valid && !word_ready) overflow <= 1'b1;

`ifdef DSO_CHSEQ_FIRST_EN
         if (start || sw)   first_pend <= 1'b1;
         else if (word_done) first_pend <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_dso_chan_seq.sv
// Bench for dso_chan_seq: mux model on the select, position-based reference model checked every
// cycle, directed scenarios with literal expectations, then a randomized run.
module tb_dso_chan_seq;
   localparam int W  = 16;
   localparam int DW = 16;
   localparam int S  = 1;

   logic          clk = 1'b0;
   logic          rst, en, sel_s, mux_y, word_chan, word_valid, word_ready, overflow, busy;
   logic [1:0]    mode;
   logic [DW-1:0] dwell;
   logic [W-1:0]  word_data;
   logic          a_bit, b_bit;
`ifdef DSO_CHSEQ_FIRST_EN
   logic          word_first;
`endif

   always #5 clk = ~clk;
   assign mux_y = sel_s ? a_bit : b_bit;

   dso_chan_seq #(.WORD_W(W), .DWELL_W(DW), .SETTLE_CYC(S)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell), .sel_s(sel_s), .mux_y(mux_y),
      .word_data(word_data), .word_chan(word_chan), .word_valid(word_valid),
      .word_ready(word_ready), .overflow(overflow), .busy(busy)
`ifdef DSO_CHSEQ_FIRST_EN
      , .word_first(word_first)
`endif
   );

   int tests = 0;
   int fails = 0;
   bit chk_on = 0;
   logic [W:0] wlog[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: everything derives from the cycle position inside the current run
   bit           m_run, m_sel, m_chan, m_valid, m_ovf, m_first, m_en_prev;
   int           m_p, m_dwell;
   logic [1:0]   m_mode;
   logic [W-1:0] m_acc, m_data;

   function automatic void pinfo(input int p, output bit ch, output bit sh, output int b, output bit fst);
      int d, seg, r;
      if (m_mode[1]) begin
         d   = (m_dwell == 0) ? 1 : m_dwell;
         seg = S + d * W;
         ch  = ((p / seg) % 2) == 0;
         r   = p % seg;
      end else begin
         ch = (m_mode != 2'b01);
         r  = p;
      end
      sh  = (r >= S);
      b   = sh ? (r - S) % W : 0;
      fst = sh && ((r - S) / W == 0);
   endfunction

   always @(posedge clk) begin
      bit ch, sh, fst, done;
      int b;
      if (rst) begin
         m_run = 0; m_sel = 1; m_chan = 1; m_valid = 0; m_ovf = 0; m_first = 0;
         m_en_prev = 0; m_data = '0; m_acc = '0; m_p = 0; m_mode = 2'b00; m_dwell = 0;
      end else begin
         done = 0;
         ch = 1; fst = 0;
         if (m_run && en) begin
            pinfo(m_p, ch, sh, b, fst);
            if (sh) begin
               m_acc = {m_acc[W-2:0], (ch ? a_bit : b_bit)};
               done  = (b == W - 1);
            end
         end
         if (done) begin
            if (!m_valid || word_ready) begin
               m_data = m_acc; m_chan = ch; m_valid = 1; m_first = fst;
            end else m_ovf = 1;
         end else if (m_valid && word_ready) m_valid = 0;
         if (en && !m_en_prev) m_ovf = 0;
         if (!m_run) begin
            if (en) begin
               m_run = 1; m_p = 0; m_mode = mode; m_dwell = int'(dwell);
               m_sel = (mode != 2'b01);
            end
         end else if (!en) begin
            m_run = 0;
         end else begin
            m_p++;
            pinfo(m_p, ch, sh, b, fst);
            m_sel = ch;
         end
         m_en_prev = en;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("sel_s", 32'(sel_s), 32'(m_sel));
         chk("busy", 32'(busy), 32'(m_run));
         chk("word_valid", 32'(word_valid), 32'(m_valid));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (m_valid) begin
            chk("word_data", 32'(word_data), 32'(m_data));
            chk("word_chan", 32'(word_chan), 32'(m_chan));
`ifdef DSO_CHSEQ_FIRST_EN
            chk("word_first", 32'(word_first), 32'(m_first));
`endif
         end
         if (word_valid && word_ready) wlog.push_back({word_chan, word_data});
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_run(input logic [1:0] md, input int dw);
      en = 0; step(2);
      wlog.delete();
      mode = md; dwell = DW'(dw); en = 1;
   endtask

   task automatic wait_words(input int n, input string nm);
      int c = 0;
      while (wlog.size() < n && c < 400) begin step(1); c++; end
      chk({nm, "_count"}, 32'(wlog.size() >= n), 32'd1);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_sel"}, 32'(sel_s), 32'd1);
      chk({nm, "_valid"}, 32'(word_valid), 32'd0);
      chk({nm, "_data"}, 32'(word_data), 32'd0);
      chk({nm, "_chan"}, 32'(word_chan), 32'd1);
      chk({nm, "_ovf"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      logic [15:0] pat16;
      logic [31:0] pat32;
      logic [W:0]  exp5[5];
      logic [W:0]  exp3[3];
      int n;
      exp5 = '{17'h1FFFF, 17'h1FFFF, 17'h00000, 17'h00000, 17'h1FFFF};
      exp3 = '{17'h1FFFF, 17'h00000, 17'h1FFFF};
      rst = 1; en = 0; mode = 2'b00; dwell = '0; word_ready = 1; a_bit = 0; b_bit = 0;
      @(posedge clk); #1; chk_on = 1;
      step(1); rst = 0;
      check_reset_vals("por");

      // single channel A, known word, latency from enable
      pat16 = 16'hA5C3;
      mode = 2'b00; en = 1;
      step(2);
      for (int k = W - 1; k >= 0; k--) begin
         a_bit = pat16[k];
         step(1);
         if (k == 1) chk("a5c3_early", 32'(word_valid), 32'd0);
      end
      chk("a5c3_valid", 32'(word_valid), 32'd1);
      chk("a5c3_data", 32'(word_data), 32'hA5C3);
      chk("a5c3_chan", 32'(word_chan), 32'd1);

      // alternate, dwell 2
      a_bit = 1; b_bit = 0; word_ready = 1;
      start_run(2'b10, 2);
      wait_words(5, "dwell2");
      for (int i = 0; i < 5; i++) if (i < wlog.size()) chk("dwell2_word", 32'(wlog[i]), 32'(exp5[i]));

      // alternate, dwell 0 behaves as 1
      start_run(2'b11, 0);
      wait_words(3, "dwell0");
      for (int i = 0; i < 3; i++) if (i < wlog.size()) chk("dwell0_word", 32'(wlog[i]), 32'(exp3[i]));

      // backpressure across two completions
      word_ready = 0;
      start_run(2'b00, 1);
      pat32 = 32'h1234BEEF;
      step(2);
      for (int k = 31; k >= 0; k--) begin a_bit = pat32[k]; step(1); end
      chk("bp_valid", 32'(word_valid), 32'd1);
      chk("bp_held", 32'(word_data), 32'h1234);
      chk("bp_ovf", 32'(overflow), 32'd1);
      word_ready = 1; step(1);
      chk("bp_accepted", 32'(word_valid), 32'd0);
      chk("bp_logged", 32'(wlog.size() == 1 ? wlog[0] : 0), 32'h11234);
      chk("bp_ovf_sticky", 32'(overflow), 32'd1);
      en = 0; step(1);
      chk("bp_ovf_en0", 32'(overflow), 32'd1);
      en = 1; step(1);
      chk("bp_ovf_clear", 32'(overflow), 32'd0);

      // abort mid-word, then restart
      start_run(2'b00, 1);
      step(2);
      for (int k = 0; k < 7; k++) begin a_bit = k[0]; step(1); end
      en = 0; step(1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(word_valid), 32'd0);
      step(1);
      chk("abort_noword", 32'(wlog.size()), 32'd0);
      en = 1; n = 0;
      do begin step(1); n++; end while (!word_valid && n < 40);
      chk("restart_latency", 32'(n), 32'(1 + S + W));
`ifdef DSO_CHSEQ_FIRST_EN
      chk("restart_first", 32'(word_first), 32'd1);
`endif

      // reset in the middle of SHIFT with overflow set
      word_ready = 0; step(40);
      rst = 1; step(1);
      check_reset_vals("rst1");
      step(1);
      check_reset_vals("rst2");
      rst = 0; en = 0; word_ready = 1; step(2);

      // randomized run
      for (int c = 0; c < 6000; c++) begin
         a_bit = 1'($urandom); b_bit = 1'($urandom);
         word_ready = ($urandom % 4) != 0;
         if ($urandom % 100 < 2) begin
            if (!en) begin mode = 2'($urandom); dwell = DW'($urandom % 4); end
            en = ~en;
         end
         step(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
